// File: rtl/fpall_pkg.sv
// Shared types for the FP datapath units and their issue/collect front ends.
package fpall_pkg;

  typedef enum logic [2:0] {
    FP_OP_ADD = 3'd0,
    FP_OP_SUB = 3'd1,
    FP_OP_MUL = 3'd2,
    FP_OP_FMA = 3'd3,
    FP_OP_MIN = 3'd4,
    FP_OP_MAX = 3'd5,
    FP_OP_CVT = 3'd6,
    FP_OP_CMP = 3'd7
  } fp_op_e;

  typedef enum logic [1:0] {
    FP_FMT_FP32 = 2'd0,
    FP_FMT_FP16 = 2'd1,
    FP_FMT_BF16 = 2'd2,
    FP_FMT_FP8  = 2'd3
  } fp_fmt_e;

  typedef struct packed {
    logic [31:0] r;
    fp_fmt_e     fmt;
  } fp_res_entry_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous first-word-fall-through FIFO with arbitrary (non power-of-two) depth.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module fp_result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // At full, wr_ptr == rd_ptr: the head is read this cycle and overwritten at the edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/fpu_issue_collector.sv
// Issue/collect front end for a fixed-latency, unhandshaked FP pipeline.
// Credits reserve a FIFO slot per issued op, so results are never dropped.
module fpu_issue_collector
  import fpall_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_op_e           in_opcode,
  input  fp_fmt_e          in_fmt,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output fp_op_e           u_opcode,
  output fp_fmt_e          u_fmt,
  output logic [31:0]      u_x,
  output logic [31:0]      u_y,
  input  logic [31:0]      u_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output fp_fmt_e          out_fmt,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(fp_res_entry_t) + TAG_W;

  logic [CW-1:0]    credits;
  logic             issue, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;
  fp_res_entry_t    wr_entry, head;

  logic [LATENCY-1:0] trk_valid;
  logic [TAG_W-1:0]   trk_tag [LATENCY];
  fp_fmt_e            trk_fmt [LATENCY];

  // Handshake signals depend only on registers (and reset), never on out_ready.
  assign in_ready  = !rst && (credits != '0);
  assign issue     = in_valid && in_ready;
  assign out_valid = !rst && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = !rst && ((|trk_valid) || !fifo_empty);

  always_comb begin
    u_opcode = fp_op_e'('0);
    u_fmt    = fp_fmt_e'('0);
    u_x      = '0;
    u_y      = '0;
    if (issue) begin
      u_opcode = in_opcode;
      u_fmt    = in_fmt;
      u_x      = in_x;
      u_y      = in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid <= '0;
    end else begin
      trk_valid[0] <= issue;
      for (int i = 1; i < LATENCY; i++) trk_valid[i] <= trk_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    trk_tag[0] <= in_tag;
    trk_fmt[0] <= in_fmt;
    for (int i = 1; i < LATENCY; i++) begin
      trk_tag[i] <= trk_tag[i-1];
      trk_fmt[i] <= trk_fmt[i-1];
    end
  end

  assign wr_entry   = '{r: u_r, fmt: trk_fmt[LATENCY-1]};
  assign fifo_wdata = {trk_tag[LATENCY-1], wr_entry};

  fp_result_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (trk_valid[LATENCY-1]),
    .push_data(fifo_wdata),
    .pop      (pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign {out_tag, head} = fifo_rdata;
  assign out_r   = head.r;
  assign out_fmt = head.fmt;

  // Every slot is either a free credit, an op in the unit, or a stored result.
  always @(posedge clk) begin
    if (!rst) begin
      assert (int'(credits) + int'(fifo_count) + $countones(trk_valid) == DEPTH);
      assert (!(trk_valid[LATENCY-1] && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_fpu_issue_collector.sv
// Self-checking bench: XOR unit model behind LATENCY delay, queue scoreboard in issue order.
module tb_fpu_issue_collector;
  import fpall_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  fp_op_e           in_opcode = FP_OP_ADD;
  fp_fmt_e          in_fmt = FP_FMT_FP32;
  logic [31:0]      in_x = '0, in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  fp_op_e           u_opcode;
  fp_fmt_e          u_fmt;
  logic [31:0]      u_x, u_y, u_r;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  fp_fmt_e          out_fmt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  fpu_issue_collector #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_fmt(in_fmt),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .u_opcode(u_opcode), .u_fmt(u_fmt), .u_x(u_x), .u_y(u_y), .u_r(u_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
    .out_fmt(out_fmt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unit model: result = x ^ y, LAT cycles after operands are presented.
  logic [31:0] upipe [LAT];
  always @(posedge clk) begin
    upipe[0] <= u_x ^ u_y;
    for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign u_r = upipe[LAT-1];

  // Reference model: results in issue order; slots held = accepted - consumed.
  logic [31:0]      q_r   [$];
  logic [TAG_W-1:0] q_tag [$];
  fp_fmt_e          q_fmt [$];
  int               outstanding = 0;

  logic             s_in_ready, s_out_valid, s_busy, s_issue, s_pop, s_exp_ready, s_head_ok;
  logic [31:0]      s_out_r, s_ux, s_uy, s_exp_r;
  logic [TAG_W-1:0] s_out_tag, s_exp_tag;
  fp_fmt_e          s_out_fmt, s_exp_fmt, s_ufmt;
  fp_op_e           s_uop;
  int               s_credits, s_exp_credits;

  task automatic snapshot();
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_busy      = busy;
    s_out_r     = out_r;
    s_out_tag   = out_tag;
    s_out_fmt   = out_fmt;
    s_ux        = u_x;
    s_uy        = u_y;
    s_uop       = u_opcode;
    s_ufmt      = u_fmt;
    s_credits   = int'(dut.credits);
  endtask

  // One cycle: drive at negedge, sample 1ns later, advance the model by the handshakes seen.
  task automatic step(input logic v, input fp_op_e op, input fp_fmt_e f, input logic [31:0] x,
                      input logic [31:0] y, input logic [TAG_W-1:0] tag, input logic ordy);
    @(negedge clk);
    in_valid = v; in_opcode = op; in_fmt = f; in_x = x; in_y = y; in_tag = tag; out_ready = ordy;
    #1;
    snapshot();
    s_exp_ready   = (outstanding < DEPTH);
    s_exp_credits = DEPTH - outstanding;
    s_issue       = v && s_in_ready;
    s_pop         = s_out_valid && ordy;
    s_head_ok     = 1'b1;
    if (s_pop) begin
      if (q_r.size() == 0) s_head_ok = 1'b0;
      else begin
        s_exp_r   = q_r.pop_front();
        s_exp_tag = q_tag.pop_front();
        s_exp_fmt = q_fmt.pop_front();
      end
    end
    if (s_issue) begin
      q_r.push_back(x ^ y);
      q_tag.push_back(tag);
      q_fmt.push_back(f);
    end
    outstanding += int'(s_issue) - int'(s_pop);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, FP_OP_ADD, FP_FMT_FP32, 32'h0, 32'h0, '0, ordy);
  endtask

  task automatic rand_step(input logic v, input logic ordy);
    step(v, fp_op_e'(3'($urandom_range(0, 7))), fp_fmt_e'(2'($urandom_range(0, 3))),
         $urandom, $urandom, TAG_W'($urandom_range(0, 15)), ordy);
  endtask

  // One-cycle reset pulse; samples outputs while rst is high.
  task automatic do_reset(input logic v, input logic [31:0] x);
    @(negedge clk);
    rst = 1'b1; in_valid = v; in_x = x; in_y = x; in_opcode = FP_OP_MUL; out_ready = 1'b1;
    #1;
    snapshot();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q_r.delete(); q_tag.delete(); q_fmt.delete();
    outstanding = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 32'hDEAD_BEEF);
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", s_in_ready); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", s_busy); end
    checks++; if (s_ux !== 32'h0) begin errors++; $display("FAIL rst_u_x got=%h exp=0", s_ux); end
    idle(1'b0);
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", s_in_ready); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", s_busy); end
    checks++; if (s_credits != DEPTH) begin errors++; $display("FAIL post_rst_credits got=%0d exp=%0d", s_credits, DEPTH); end
  endtask

  task automatic test_single();
    logic exp_valid, exp_busy;
    step(1'b1, FP_OP_MUL, FP_FMT_BF16, 32'h3FC0_0000, 32'h4000_0000, 4'd5, 1'b1);
    checks++; if (s_issue !== 1'b1) begin errors++; $display("FAIL single_issue got=%b exp=1", s_issue); end
    checks++; if (s_ux !== 32'h3FC0_0000 || s_uop !== FP_OP_MUL) begin errors++; $display("FAIL single_u_x got=%h op=%0d exp=3fc00000 op=2", s_ux, s_uop); end
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1);
      exp_valid = (k == LAT + 1);
      exp_busy  = (k <= LAT + 1);
      checks++; if (s_out_valid !== exp_valid) begin errors++; $display("FAIL single_out_valid t+%0d got=%b exp=%b", k, s_out_valid, exp_valid); end
      checks++; if (s_busy !== exp_busy) begin errors++; $display("FAIL single_busy t+%0d got=%b exp=%b", k, s_busy, exp_busy); end
      if (exp_valid) begin
        checks++; if (s_out_r !== 32'h7FC0_0000) begin errors++; $display("FAIL single_out_r got=%h exp=7fc00000", s_out_r); end
        checks++; if (s_out_tag !== 4'd5) begin errors++; $display("FAIL single_out_tag got=%0d exp=5", s_out_tag); end
        checks++; if (s_out_fmt !== FP_FMT_BF16) begin errors++; $display("FAIL single_out_fmt got=%0d exp=2", s_out_fmt); end
      end
    end
  endtask

  task automatic test_backpressure();
    int npop = 0;
    int first_pop = -1;
    int cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, FP_OP_MUL, FP_FMT_FP32, $urandom, $urandom, TAG_W'(i), 1'b0);
      checks++; if (s_in_ready !== (i < DEPTH)) begin errors++; $display("FAIL bp_in_ready attempt=%0d got=%b exp=%b", i, s_in_ready, (i < DEPTH)); end
    end
    while (npop < DEPTH && cyc < 20) begin
      idle(1'b1);
      if (first_pop >= 0 && cyc == first_pop + 1) begin
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", s_in_ready); end
      end
      if (s_pop) begin
        if (first_pop < 0) begin
          first_pop = cyc;
          checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at_pop got=%b exp=0", s_in_ready); end
        end
        checks++; if (!s_head_ok || s_out_tag !== TAG_W'(npop) || s_out_r !== s_exp_r) begin
          errors++; $display("FAIL bp_order got tag=%0d r=%h exp tag=%0d r=%h", s_out_tag, s_out_r, npop, s_exp_r); end
        npop++;
      end
      cyc++;
    end
    checks++; if (npop != DEPTH) begin errors++; $display("FAIL bp_drain_timeout got=%0d exp=%0d pops", npop, DEPTH); end
    idle(1'b1);
    checks++; if (s_out_valid !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL bp_final got valid=%b busy=%b exp 0 0", s_out_valid, s_busy); end
  endtask

  task automatic test_streaming();
    int npop = 0;
    int cyc = 0;
    logic started = 1'b0;
    int ready_drops = 0;
    for (int i = 0; i < 100 + 20 && npop < 100; i++) begin
      rand_step(i < 100, 1'b1);
      if (i < 100) begin
        checks++; if (s_in_ready !== 1'b1 || s_exp_ready !== 1'b1) begin
          errors++; ready_drops++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, s_in_ready); end
        checks++; if (s_ux !== in_x || s_uy !== in_y) begin errors++; $display("FAIL stream_u_xy got=%h/%h exp=%h/%h", s_ux, s_uy, in_x, in_y); end
      end
      if (started) begin
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap i=%0d got=%b exp=1", i, s_out_valid); end
      end
      if (s_out_valid) started = 1'b1;
      if (s_pop) begin
        checks++; if (!s_head_ok || s_out_r !== s_exp_r || s_out_tag !== s_exp_tag || s_out_fmt !== s_exp_fmt) begin
          errors++; $display("FAIL stream_data n=%0d got r=%h tag=%0d fmt=%0d exp r=%h tag=%0d fmt=%0d",
                             npop, s_out_r, s_out_tag, s_out_fmt, s_exp_r, s_exp_tag, s_exp_fmt); end
        npop++;
      end
      cyc = i;
    end
    checks++; if (npop != 100) begin errors++; $display("FAIL stream_count got=%0d exp=100 (cycles=%0d)", npop, cyc); end
  endtask

  task automatic test_full_toggle();
    logic prev_stall = 1'b0;
    logic [31:0] prev_r = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    int cyc = 0;
    for (int i = 0; i < DEPTH + LAT + 1; i++) rand_step(1'b1, 1'b0);
    checks++; if (s_credits != 0 || s_in_ready !== 1'b0) begin errors++; $display("FAIL full_fill credits=%0d ready=%b exp 0 0", s_credits, s_in_ready); end
    for (int i = 0; i < 40; i++) begin
      rand_step(1'b1, i[0]);
      checks++; if (s_in_ready !== s_exp_ready) begin errors++; $display("FAIL full_in_ready i=%0d got=%b exp=%b", i, s_in_ready, s_exp_ready); end
      checks++; if (s_credits != s_exp_credits || s_credits > DEPTH) begin errors++; $display("FAIL full_credits i=%0d got=%0d exp=%0d", i, s_credits, s_exp_credits); end
      if (prev_stall) begin
        checks++; if (s_out_valid !== 1'b1 || s_out_r !== prev_r || s_out_tag !== prev_tag) begin
          errors++; $display("FAIL full_stable i=%0d got v=%b r=%h tag=%0d exp v=1 r=%h tag=%0d", i, s_out_valid, s_out_r, s_out_tag, prev_r, prev_tag); end
      end
      prev_stall = s_out_valid && !i[0];
      prev_r = s_out_r; prev_tag = s_out_tag;
      if (s_pop) begin
        checks++; if (!s_head_ok || s_out_r !== s_exp_r || s_out_tag !== s_exp_tag || s_out_fmt !== s_exp_fmt) begin
          errors++; $display("FAIL full_data i=%0d got r=%h tag=%0d exp r=%h tag=%0d", i, s_out_r, s_out_tag, s_exp_r, s_exp_tag); end
      end
    end
    while (outstanding > 0 && cyc < 30) begin
      idle(1'b1);
      if (s_pop) begin
        checks++; if (!s_head_ok || s_out_r !== s_exp_r || s_out_tag !== s_exp_tag) begin
          errors++; $display("FAIL full_drain got r=%h tag=%0d exp r=%h tag=%0d", s_out_r, s_out_tag, s_exp_r, s_exp_tag); end
      end
      cyc++;
    end
    checks++; if (outstanding != 0) begin errors++; $display("FAIL full_drain_timeout got=%0d exp=0 outstanding", outstanding); end
    idle(1'b1);
    checks++; if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_credits != DEPTH) begin
      errors++; $display("FAIL full_final got v=%b busy=%b credits=%0d exp 0 0 %0d", s_out_valid, s_busy, s_credits, DEPTH); end
  endtask

  task automatic test_reset_midflight();
    rand_step(1'b1, 1'b1);
    rand_step(1'b1, 1'b1);
    do_reset(1'b0, 32'h0);
    idle(1'b1);
    checks++; if (s_credits != DEPTH) begin errors++; $display("FAIL mid_credits got=%0d exp=%0d", s_credits, DEPTH); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", s_busy); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", s_in_ready); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) idle(1'b1);
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid k=%0d got=%b exp=0", k, s_out_valid); end
    end
  endtask

  task automatic test_idle_operands();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, fp_op_e'(3'($urandom_range(1, 7))), fp_fmt_e'(2'($urandom_range(1, 3))),
           $urandom | 32'h1, $urandom | 32'h1, '0, 1'b0);
      checks++; if (s_ux !== 32'h0 || s_uy !== 32'h0 || s_uop !== fp_op_e'(3'd0) || s_ufmt !== fp_fmt_e'(2'd0)) begin
        errors++; $display("FAIL idle_operands k=%0d got x=%h y=%h op=%0d fmt=%0d exp all 0", k, s_ux, s_uy, s_uop, s_ufmt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_full_toggle();
    test_reset_midflight();
    test_idle_operands();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_collector.md
# fpu_issue_collector

Issue and collect front end for a fixed-latency, fully pipelined FP datapath unit such as the bf16 multiplier. Upstream sees a valid/ready request channel. Downstream sees a valid/ready result channel. The block drives operands into the unit, which has no handshake, and tracks each issued operation through the unit's LATENCY stages. Results are captured into a credit-protected result FIFO, so no result is ever dropped under downstream backpressure.

## Interface
- LATENCY, 2: cycles from operand presentation on u_* to valid u_r; must be ≥1.
- DEPTH, 4: result FIFO entries; must be ≥1. Full throughput requires DEPTH ≥ LATENCY+2.
- TAG_W, 4: width of the opaque request tag.
- clk  in  1  single clock. Reset is synchronous and active-high, sampled on posedge clk.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_opcode  in  fp_op_e  operation.
- in_fmt  in  fp_fmt_e  format.
- in_x, in_y  in  32  operands.
- in_tag  in  TAG_W  returned with the result.
- u_opcode  out  fp_op_e  operation driven to the unit.
- u_fmt  out  fp_fmt_e  format driven to the unit.
- u_x, u_y  out  32  operands driven to the unit.
- u_r  in  32  unit result.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_r  out  32  result.
- out_tag  out  TAG_W  tag of the result.
- out_fmt  out  fp_fmt_e  format of the result.
- busy  out  1  any operation in flight or in the FIFO.

## Operation
- Credit counter, range 0..DEPTH; reset value DEPTH. in_ready = (credits != 0), driven from the register only, with no combinational path from out_ready.
- Issue (in_valid && in_ready) decrements the credit counter. Pop (out_valid && out_ready) increments it. Issue and pop in the same cycle leave it unchanged.
- u_x, u_y, u_opcode and u_fmt are combinational copies of the in_* signals on issue cycles, and all-zero on every other cycle, so the unit sees deterministic idle operands.
- Tracking pipe, LATENCY stages, each stage holding {valid, tag, fmt}. Stage 0 loads {issue, in_tag, in_fmt}. Stage LATENCY-1 aligns with u_r.
- When the last tracking stage is valid, {u_r, tag, fmt} are written into the FIFO that cycle. u_r on cycles where the last stage is invalid is ignored.
- FIFO behaviour:
  - First-word-fall-through: out_* reflect the head entry, and out_valid = !empty.
  - Push and pop in the same cycle is legal at any occupancy, including full (the pop frees the slot) and empty (the entry appears the following cycle; there is no same-cycle bypass).
  - Pointers wrap modulo DEPTH, with no power-of-two restriction.
  - Results leave strictly in issue order.
- Credits guarantee that a push never occurs on a full FIFO without a simultaneous pop. This is asserted in simulation.
- busy = |tracking valid bits || !empty.
- Reset clears the credits to DEPTH, all tracking valid bits, and the FIFO pointers and count. Operations still in flight inside the unit at reset are discarded, because their valid bits are gone. out_* data need not be reset.
- While rst is high: in_ready=0, out_valid=0, busy=0, u_* = 0.

## Timing
- Reset values: in_ready=1 in the first cycle after reset deasserts; out_valid=0; busy=0.
- Latency: issue in cycle t with the FIFO empty gives out_valid in cycle t+LATENCY+1.
- Credit round trip is LATENCY+2 cycles. With DEPTH ≥ LATENCY+2 and out_ready held at 1, one issue per cycle is sustained indefinitely.
- With out_ready=0, exactly DEPTH requests are accepted, then in_ready=0 until the first pop. in_ready returns in the cycle after that pop.
- out_* remain stable while out_valid && !out_ready.

## Structure
- fpall_pkg already holds fp_op_e and fp_fmt_e.
- Add to fpall_pkg a packed struct fp_res_entry_t {logic [31:0] r; fp_fmt_e fmt;}. The tag stays parameterised locally.
- One sub-module: fp_result_fifo, a parameterised synchronous FWFT FIFO (WIDTH, DEPTH) with full, empty and count outputs. It is reusable for the other FP units.
- The tracking pipe and credit counter stay in the top-level block.

## Test plan
- Bench unit model: u_r = u_x ^ u_y delayed by LATENCY. LATENCY=2, DEPTH=4.
- Single op: issue x=0x3FC00000, y=0x40000000, tag=5 in cycle t, out_ready=1 -> out_valid in cycle t+3 with out_r=0x7FC00000, out_tag=5, one cycle only. busy is high from t+1 to t+3.
- Backpressure: out_ready=0, 6 back-to-back requests with tags 0..5 -> only tags 0..3 accepted and in_ready=0 from the 5th attempt onward. Raising out_ready pops tags 0,1,2,3 in order, and in_ready=1 the cycle after the first pop.
- Streaming: out_ready=1, 100 consecutive requests -> in_ready never deasserts, 100 results arrive in order, and out_valid is continuous after the first.
- Simultaneous push/pop at full: fill to 4 with pops blocked, then toggle out_ready 1/0 while issuing whenever ready -> no overflow assertion, no lost or duplicated tag, and the credit counter never exceeds 4.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle at t+1 -> no out_valid afterwards from those ops, credits=4, busy=0 the cycle after reset deasserts.
- Idle operands: in_valid=0 with nonzero in_x -> u_x=0 and u_opcode=0 every cycle.
